// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: op encoding, FSM states and op decode helpers.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOTA = 4'd7;
    localparam logic [3:0] OP_PASA = 4'd8;
    localparam logic [3:0] OP_PASB = 4'd9;
    localparam logic [3:0] OP_SLL  = 4'd10;
    localparam logic [3:0] OP_SRL  = 4'd11;
    localparam logic [3:0] OP_SRA  = 4'd12;
    localparam logic [3:0] OP_INC  = 4'd13;
    localparam logic [3:0] OP_DEC  = 4'd14;
    localparam logic [3:0] OP_HAM  = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Mul and div need the long settle window in the shared ALU.
    function automatic logic op_is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_arb_seq_if.sv
// Bundle of requester, ALU and response signals around the ALU sequencer.
interface alu_arb_seq_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [3:0]       req0_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [3:0]       req1_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_sel;
    logic [WIDTH-1:0] alu_res;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;
    logic             busy;

    modport slave (
        input  req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
        input  alu_res, rsp_ready,
        output req_ready, alu_a, alu_b, alu_sel,
        output rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );

    modport master (
        output req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
        output alu_res, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_sel,
        input  rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );

endinterface

// File: rtl/alu_arb_seq_rr_arb_2.sv
// Two-requester round-robin arbiter; the pointer names the requester preferred on a tie
// and moves to the other requester after each granted cycle with advance set.
module rr_arb_2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic r_ptr;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = r_ptr ? 2'b10 : 2'b01;
        end
    end

    // grant[0] set means requester 0 won, so requester 1 is preferred next.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (advance && (grant != 2'b00)) begin
            r_ptr <= grant[0];
        end
    end

endmodule

// File: rtl/alu_arb_seq.sv
// Sequencer sharing one multicycle ALU between two requesters: grants one op, holds the
// ALU inputs for the op's settle time, then returns the tagged result on one response port.
module alu_arb_seq
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MULDIV_LAT = 4,
    parameter int SIMPLE_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arb_seq_if.slave  bus
);

    localparam logic [3:0] LAT_MULDIV = 4'(MULDIV_LAT - 1);
    localparam logic [3:0] LAT_SIMPLE = 4'(SIMPLE_LAT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [3:0]       r_alu_sel;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_id;
    logic             r_rsp_err;

    logic             w_idle;
    logic [1:0]       w_arb_req;
    logic [1:0]       w_grant;
    logic             w_accept;
    logic             w_gid;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [3:0]       w_op;
    logic             w_div0;
    logic [3:0]       w_lat;

    assign w_idle    = (r_state == IDLE);
    assign w_arb_req = w_idle ? bus.req_valid : 2'b00;

    rr_arb_2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (w_arb_req),
        .advance (w_idle),
        .grant   (w_grant)
    );

    assign w_accept = (w_grant != 2'b00);
    assign w_gid    = w_grant[1];
    assign w_a      = w_gid ? bus.req1_a  : bus.req0_a;
    assign w_b      = w_gid ? bus.req1_b  : bus.req0_b;
    assign w_op     = w_gid ? bus.req1_op : bus.req0_op;
    assign w_div0   = (w_op == OP_DIV) && (w_b == '0);
    assign w_lat    = op_is_muldiv(w_op) ? LAT_MULDIV : LAT_SIMPLE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = w_div0 ? RESP : EXEC;
            EXEC:    if (r_cnt == 4'd0) w_state_nxt = RESP;
            RESP:    if (bus.rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Divide-by-zero is answered directly from the grant; the ALU result is never sampled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_sel  <= '0;
            r_rsp_data <= '0;
            r_rsp_id   <= 1'b0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_alu_a   <= w_a;
                        r_alu_b   <= w_b;
                        r_alu_sel <= w_op;
                        r_rsp_id  <= w_gid;
                        r_cnt     <= w_lat;
                        if (w_div0) begin
                            r_rsp_data <= '1;
                            r_rsp_err  <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (r_cnt == 4'd0) begin
                        r_rsp_data <= bus.alu_res;
                        r_rsp_err  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_sel   = r_alu_sel;
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.busy      = !w_idle;

endmodule
